// File: rtl/amdc_isr_gen_pkg.sv
// Shared mode encodings, bit positions and defaults for the multi-channel ISR generator.
package amdc_isr_gen_pkg;

  localparam int MODE_HIGH_BIT = 0;
  localparam int MODE_LOW_BIT  = 1;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_HIGH = 2'b01,
    MODE_LOW  = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // Peak and valley in the same cycle collapse into a single event.
  function automatic logic eventQualify(input logic [1:0] mode,
                                        input logic       high,
                                        input logic       low);
    return (mode[MODE_HIGH_BIT] & high) | (mode[MODE_LOW_BIT] & low);
  endfunction

endpackage

// File: rtl/amdc_isr_gen_ch.sv
// One ISR channel: event counter, shadow ratio, enable-edge detect and optional sticky flags.
// Pending/overrun tracking is built only when AMDC_ISR_GEN_MC_PENDING_EN is defined.
module amdc_isr_gen_ch
  import amdc_isr_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             event_i,
  input  logic [CNT_W-1:0] ratio_i,
  input  logic             clear_i,
  output logic             irq_o,
  output logic             pending_o,
  output logic             overrun_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             enPrev_q;
  logic             irq_q, irq_d;
  logic             enRise;

  assign enRise = enable_i & ~enPrev_q;

  // The shadow ratio is only reloaded at enable and at wrap, so ratio writes never cut a period short.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    irq_d    = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (enRise) begin
      cnt_d    = '0;
      shadow_d = ratio_i;
    end else if (event_i) begin
      if (cnt_q == shadow_q) begin
        cnt_d    = '0;
        irq_d    = 1'b1;
        shadow_d = ratio_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      enPrev_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      enPrev_q <= enable_i;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;

`ifdef AMDC_ISR_GEN_MC_PENDING_EN
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;

  // Flags track the visible interrupt pulse; a clear during a pulse keeps pending but drops overrun.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (clear_i) begin
      pending_d = irq_q;
      overrun_d = 1'b0;
    end else if (irq_q) begin
      pending_d = 1'b1;
      overrun_d = overrun_q | pending_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;
`else
  logic unusedClear;
  assign unusedClear = clear_i;
  assign pending_o   = 1'b0;
  assign overrun_o   = 1'b0;
`endif

endmodule

// File: rtl/amdc_isr_gen_mc.sv
// Multi-channel ISR generator top: slices per-channel controls and qualifies carrier events.
// Optional pending/overrun flags: define AMDC_ISR_GEN_MC_PENDING_EN.
module amdc_isr_gen_mc
  import amdc_isr_gen_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm_carrier_high,
  input  logic                  pwm_carrier_low,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [2*N_CH-1:0]     ch_mode,
  input  logic [N_CH*CNT_W-1:0] user_ratio,
  input  logic [N_CH-1:0]       irq_clear,
  output logic [N_CH-1:0]       interrupt,
  output logic [N_CH-1:0]       irq_pending,
  output logic [N_CH-1:0]       irq_overrun
);

  for (genvar i = 0; i < N_CH; i++) begin : gCh
    logic chEvent;

    assign chEvent = ch_enable[i] &
                     eventQualify(ch_mode[2*i +: 2], pwm_carrier_high, pwm_carrier_low);

    amdc_isr_gen_ch #(
      .CNT_W(CNT_W)
    ) uCh (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .enable_i  (ch_enable[i]),
      .event_i   (chEvent),
      .ratio_i   (user_ratio[CNT_W*i +: CNT_W]),
      .clear_i   (irq_clear[i]),
      .irq_o     (interrupt[i]),
      .pending_o (irq_pending[i]),
      .overrun_o (irq_overrun[i])
    );
  end

endmodule

// File: tb/tb_amdc_isr_gen_mc.sv
// Directed, table-driven bench for amdc_isr_gen_mc (4 x 16-bit) plus a 1 x 3-bit instance for counter wrap.
// Builds with or without AMDC_ISR_GEN_MC_PENDING_EN; flag expectations follow the macro.
module tb_amdc_isr_gen_mc;
  import amdc_isr_gen_pkg::*;

`ifdef AMDC_ISR_GEN_MC_PENDING_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  localparam logic [1:0] MN = MODE_NONE;
  localparam logic [1:0] MH = MODE_HIGH;
  localparam logic [1:0] ML = MODE_LOW;
  localparam logic [1:0] MB = MODE_BOTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        high, low;
  logic [3:0]  enable;
  logic [7:0]  mode;
  logic [63:0] ratio;
  logic [3:0]  clear;
  logic [3:0]  interrupt, irqPending, irqOverrun;

  logic sEnable, sHigh, sIrq, sPend, sOvr;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic        high;
    logic        low;
    logic [3:0]  enable;
    logic [7:0]  mode;
    logic [63:0] ratio;
    logic [3:0]  expIrq;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  amdc_isr_gen_mc #(.N_CH(4), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pwm_carrier_high (high),
    .pwm_carrier_low  (low),
    .ch_enable        (enable),
    .ch_mode          (mode),
    .user_ratio       (ratio),
    .irq_clear        (clear),
    .interrupt        (interrupt),
    .irq_pending      (irqPending),
    .irq_overrun      (irqOverrun)
  );

  amdc_isr_gen_mc #(.N_CH(1), .CNT_W(3)) dutSmall (
    .clk              (clk),
    .rst_n            (rst_n),
    .pwm_carrier_high (sHigh),
    .pwm_carrier_low  (1'b0),
    .ch_enable        (sEnable),
    .ch_mode          (MH),
    .user_ratio       (3'd7),
    .irq_clear        (1'b0),
    .interrupt        (sIrq),
    .irq_pending      (sPend),
    .irq_overrun      (sOvr)
  );

  function automatic logic [63:0] packRatio(input int r0, input int r1, input int r2, input int r3);
    return {16'(r3), 16'(r2), 16'(r1), 16'(r0)};
  endfunction

  task automatic addVec(input logic h, input logic l, input logic [3:0] en,
                        input logic [7:0] md, input logic [63:0] rt, input logic [3:0] exp);
    vec_t v;
    v.high = h; v.low = l; v.enable = en; v.mode = md; v.ratio = rt; v.expIrq = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge that sampled them.
  task automatic applyStimulus(input logic h, input logic l, input logic [3:0] en,
                               input logic [7:0] md, input logic [63:0] rt, input logic [3:0] clr);
    high = h; low = l; enable = en; mode = md; ratio = rt; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [63:0] r;

    // Ch0 HIGH, ratio 3: pulse on every 4th peak, valleys ignored.
    r = packRatio(3, 0, 0, 0);
    addVec(0, 0, 4'b0001, {6'b0, MH}, r, 4'b0000);
    for (int k = 1; k <= 12; k++) begin
      addVec(1, 0, 4'b0001, {6'b0, MH}, r, (k % 4 == 0) ? 4'b0001 : 4'b0000);
      addVec(0, 1, 4'b0001, {6'b0, MH}, r, 4'b0000);
    end
    addVec(0, 0, 4'b0000, {6'b0, MH}, r, 4'b0000);

    // Ch1 BOTH, ratio 1: simultaneous peak+valley is one event.
    r = packRatio(0, 1, 0, 0);
    addVec(0, 0, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0000);
    addVec(1, 0, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0000);
    addVec(0, 1, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0010);
    addVec(1, 0, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0000);
    addVec(0, 1, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0010);
    addVec(1, 1, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0000);
    addVec(1, 0, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0010);
    addVec(1, 1, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0000);
    addVec(1, 1, 4'b0010, {4'b0, MB, 2'b0}, r, 4'b0010);
    addVec(0, 0, 4'b0000, {4'b0, MB, 2'b0}, r, 4'b0000);

    // Ch2 ratio 5 changed to 1 after two events: old ratio holds until the wrap.
    addVec(0, 0, 4'b0100, {2'b0, MH, 4'b0}, packRatio(0, 0, 5, 0), 4'b0000);
    for (int k = 1; k <= 2; k++) addVec(1, 0, 4'b0100, {2'b0, MH, 4'b0}, packRatio(0, 0, 5, 0), 4'b0000);
    for (int k = 3; k <= 10; k++)
      addVec(1, 0, 4'b0100, {2'b0, MH, 4'b0}, packRatio(0, 0, 1, 0),
             (k == 6 || k == 8 || k == 10) ? 4'b0100 : 4'b0000);
    addVec(0, 0, 4'b0000, {2'b0, MH, 4'b0}, packRatio(0, 0, 1, 0), 4'b0000);

    // Ch3 LOW ratio 0: disable mid-run, re-enable coincident with a strobe.
    r = packRatio(0, 0, 0, 0);
    addVec(0, 0, 4'b1000, {ML, 6'b0}, r, 4'b0000);
    addVec(0, 1, 4'b1000, {ML, 6'b0}, r, 4'b1000);
    addVec(0, 1, 4'b1000, {ML, 6'b0}, r, 4'b1000);
    addVec(0, 1, 4'b0000, {ML, 6'b0}, r, 4'b0000);
    addVec(0, 1, 4'b0000, {ML, 6'b0}, r, 4'b0000);
    addVec(0, 1, 4'b1000, {ML, 6'b0}, r, 4'b0000);
    addVec(0, 1, 4'b1000, {ML, 6'b0}, r, 4'b1000);
    addVec(0, 0, 4'b1000, {ML, 6'b0}, r, 4'b0000);
    addVec(0, 0, 4'b0000, {ML, 6'b0}, r, 4'b0000);

    // Ch0 ratio 1: mode NONE freezes the counter mid-period.
    r = packRatio(1, 0, 0, 0);
    addVec(0, 0, 4'b0001, {6'b0, MH}, r, 4'b0000);
    addVec(1, 0, 4'b0001, {6'b0, MH}, r, 4'b0000);
    addVec(1, 0, 4'b0001, {6'b0, MN}, r, 4'b0000);
    addVec(1, 1, 4'b0001, {6'b0, MN}, r, 4'b0000);
    addVec(0, 1, 4'b0001, {6'b0, MN}, r, 4'b0000);
    addVec(1, 0, 4'b0001, {6'b0, MH}, r, 4'b0001);
    addVec(0, 0, 4'b0000, {6'b0, MH}, r, 4'b0000);

    // All channels HIGH with ratios 0,1,0,2: independent, concurrent pulses.
    r = packRatio(0, 1, 0, 2);
    addVec(0, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b0000);
    addVec(1, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b0101);
    addVec(1, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b0111);
    addVec(1, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b1101);
    addVec(1, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b0111);
    addVec(0, 1, 4'b1111, {MH, MH, MH, MH}, r, 4'b0000);
    addVec(0, 0, 4'b0000, {MH, MH, MH, MH}, r, 4'b0000);

    // Reset state.
    rst_n = 1'b0; high = 0; low = 0; enable = '0; mode = '0; ratio = '0; clear = '0;
    sEnable = 1'b0; sHigh = 1'b0;
    #12;
    checkOutput("reset irq", interrupt, 0);
    checkOutput("reset pending", irqPending, 0);
    checkOutput("reset overrun", irqOverrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].high, vecs[k].low, vecs[k].enable, vecs[k].mode, vecs[k].ratio, 4'b0000);
      checkOutput($sformatf("vec%0d irq", k), interrupt, vecs[k].expIrq);
`ifndef AMDC_ISR_GEN_MC_PENDING_EN
      checkOutput($sformatf("vec%0d pending", k), irqPending, 0);
      checkOutput($sformatf("vec%0d overrun", k), irqOverrun, 0);
`endif
    end

    // Pending/overrun sequence on ch0, ratio 0.
    r = packRatio(0, 0, 0, 0);
    applyStimulus(0, 0, 4'b0000, {6'b0, MH}, r, 4'b1111);
    checkOutput("flags cleared pending", irqPending, 0);
    checkOutput("flags cleared overrun", irqOverrun, 0);
    applyStimulus(0, 0, 4'b0001, {6'b0, MH}, r, 4'b0000);
    applyStimulus(1, 0, 4'b0001, {6'b0, MH}, r, 4'b0000);
    checkOutput("flag pulse1 irq", interrupt, 4'b0001);
    applyStimulus(1, 0, 4'b0001, {6'b0, MH}, r, 4'b0000);
    checkOutput("flag pulse2 irq", interrupt, 4'b0001);
    checkOutput("flag pulse2 pending", irqPending, 32'(FEAT));
    checkOutput("flag pulse2 overrun", irqOverrun, 0);
    applyStimulus(0, 0, 4'b0001, {6'b0, MH}, r, 4'b0000);
    checkOutput("flag overrun pending", irqPending, 32'(FEAT));
    checkOutput("flag overrun overrun", irqOverrun, 32'(FEAT));
    applyStimulus(1, 0, 4'b0001, {6'b0, MH}, r, 4'b0000);
    checkOutput("flag pulse3 irq", interrupt, 4'b0001);
    applyStimulus(0, 0, 4'b0001, {6'b0, MH}, r, 4'b0001);
    checkOutput("clear on pulse pending", irqPending, 32'(FEAT));
    checkOutput("clear on pulse overrun", irqOverrun, 0);
    applyStimulus(0, 0, 4'b0001, {6'b0, MH}, r, 4'b0001);
    checkOutput("clear idle pending", irqPending, 0);
    checkOutput("clear idle overrun", irqOverrun, 0);
    applyStimulus(0, 0, 4'b0000, {6'b0, MH}, r, 4'b0000);

    // Async reset mid-count, then a full ratio+1 events are needed again.
    r = packRatio(0, 3, 3, 3);
    applyStimulus(0, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b0000);
    applyStimulus(1, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b0000);
    applyStimulus(1, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b0000);
    checkOutput("pre-reset irq", interrupt, 4'b0001);
    high = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset irq", interrupt, 0);
    checkOutput("async reset pending", irqPending, 0);
    checkOutput("async reset overrun", irqOverrun, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset enable edge irq", interrupt, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 4'b1111, {MH, MH, MH, MH}, r, 4'b0000);
      checkOutput($sformatf("post-reset ev%0d irq", k), interrupt, (k == 4) ? 4'b1111 : 4'b0001);
    end
    applyStimulus(0, 0, 4'b0000, {MH, MH, MH, MH}, r, 4'b0000);

    // 3-bit counter at its maximum ratio: one pulse every 8 events.
    sEnable = 1'b1;
    sHigh   = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      sHigh = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("wrap ev%0d irq", k + 1), 32'(sIrq), (k % 8 == 7) ? 1 : 0);
    end
    sHigh = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
